// File: rtl/mem_bus_responder_if.sv
// mem_bus_responder_if: processor memory request bus between control_unit and the responder
interface mem_bus_responder_if;
  logic        memory_read_req;
  logic        memory_write_req;
  logic [25:0] memory_addr;
  logic [31:0] memory_data_write;
  logic [31:0] memory_data_read;
  logic        memory_busy;
  modport master (
    output memory_read_req, memory_write_req, memory_addr, memory_data_write,
    input  memory_data_read, memory_busy
  );
  modport slave (
    input  memory_read_req, memory_write_req, memory_addr, memory_data_write,
    output memory_data_read, memory_busy
  );
endinterface

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: decodes bus requests into a local register bank, an external slow port or unmapped space
module mem_bus_responder #(
  parameter logic [31:0] ID_WORD       = 32'h5646_5058,
  parameter int          TIMEOUT       = 256,
  parameter logic [31:0] UNMAPPED_WORD = 32'hDEAD_BEEF
) (
  input  logic                clk,
  input  logic                reset,
  mem_bus_responder_if.slave  bus,
  output logic                ext_req,
  output logic                ext_we,
  output logic [23:0]         ext_addr,
  output logic [31:0]         ext_wdata,
  input  logic [31:0]         ext_rdata,
  input  logic                ext_ack,
  output logic [3:0]          led_ctrl
);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, LOCAL, EXT} state_t;
  state_t      state, state_d;
  logic [1:0]  region_q;
  logic [3:0]  idx_q;
  logic [31:0] wdata_q, reg1, reg2, cnt, rdata_q, local_rd;
  logic        rd_q, wr_q, dual_q;
  logic [15:0] err;
  logic [TW-1:0] tcnt;
  logic        accept, local_done, ext_done, timeout, done, err_inc, err_clr;
  assign accept     = state == IDLE && (bus.memory_read_req || bus.memory_write_req);
  assign local_done = state == LOCAL;
  assign ext_done   = state == EXT && ext_ack;
  assign timeout    = state == EXT && !ext_ack && tcnt == TW'(TIMEOUT - 1);
  assign done       = local_done || ext_done || timeout;
  assign err_clr    = local_done && wr_q && region_q == 2'b00 && idx_q == 4'd4;
  assign err_inc    = done && (dual_q || region_q[1] || timeout);
  assign local_rd   = idx_q == 4'd0 ? ID_WORD :
                      idx_q == 4'd1 ? reg1 :
                      idx_q == 4'd2 ? reg2 :
                      idx_q == 4'd3 ? cnt :
                      idx_q == 4'd4 ? {16'h0, err} : 32'h0;
  assign ext_req              = state == EXT;
  assign bus.memory_busy      = state != IDLE;
  assign bus.memory_data_read = rdata_q;
  assign led_ctrl             = reg2[3:0];
  // next state: accept from IDLE, return to IDLE when the transaction completes
  always_comb begin
    state_d = state;
    if (accept) state_d = bus.memory_addr[25:24] == 2'b01 ? EXT : LOCAL;
    else if (done) state_d = IDLE;
  end
  // state register
  always_ff @(posedge clk) state <= reset ? IDLE : state_d;
  // request latch, register bank, read data and error bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      region_q  <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      dual_q    <= 1'b0;
      ext_we    <= 1'b0;
      ext_addr  <= '0;
      ext_wdata <= '0;
      reg1      <= '0;
      reg2      <= '0;
      cnt       <= '0;
      rdata_q   <= '0;
      err       <= '0;
      tcnt      <= '0;
    end else begin
      cnt  <= cnt + 32'd1;
      tcnt <= state == EXT ? tcnt + 1'b1 : '0;
      if (accept) begin
        region_q <= bus.memory_addr[25:24];
        idx_q    <= bus.memory_addr[3:0];
        wdata_q  <= bus.memory_data_write;
        rd_q     <= bus.memory_read_req && !bus.memory_write_req;
        wr_q     <= bus.memory_write_req;
        dual_q   <= bus.memory_read_req && bus.memory_write_req;
        if (bus.memory_addr[25:24] == 2'b01) begin
          ext_we    <= bus.memory_write_req;
          ext_addr  <= bus.memory_addr[23:0];
          ext_wdata <= bus.memory_data_write;
        end
      end
      if (local_done && wr_q && region_q == 2'b00 && idx_q == 4'd1) reg1 <= wdata_q;
      if (local_done && wr_q && region_q == 2'b00 && idx_q == 4'd2) reg2 <= wdata_q;
      if (rd_q && local_done) rdata_q <= region_q[1] ? UNMAPPED_WORD : local_rd;
      if (rd_q && ext_done) rdata_q <= ext_rdata;
      if (rd_q && timeout) rdata_q <= UNMAPPED_WORD;
      if (err_clr) err <= '0;
      else if (err_inc && err != 16'hFFFF) err <= err + 16'd1;
    end
  end
endmodule

// File: tb/tb_mem_bus_responder.sv
// tb_mem_bus_responder: directed and randomized transactions checked against a behavioural model
module tb_mem_bus_responder;
  localparam int TO = 256;
  localparam logic [31:0] ID = 32'h5646_5058;
  localparam logic [31:0] UW = 32'hDEAD_BEEF;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ext_req, ext_we, ext_ack;
  logic [23:0] ext_addr;
  logic [31:0] ext_wdata, ext_rdata;
  logic [3:0]  led_ctrl;
  logic [31:0] tb_cyc;
  int          vectors = 0, miscompares = 0;
  logic [31:0] m_reg1, m_reg2, m_data;
  int          m_err;
  mem_bus_responder_if bus();
  mem_bus_responder #(.ID_WORD(ID), .TIMEOUT(TO), .UNMAPPED_WORD(UW)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_ack(ext_ack), .led_ctrl(led_ctrl)
  );
  always #5 clk = ~clk;
  always @(posedge clk) tb_cyc <= reset ? 32'd0 : tb_cyc + 32'd1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic drop_reqs;
    bus.memory_read_req = 1'b0;
    bus.memory_write_req = 1'b0;
  endtask
  task automatic model_reset;
    m_reg1 = 0;
    m_reg2 = 0;
    m_data = 0;
    m_err = 0;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    drop_reqs();
    ext_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask
  task automatic txn(input logic rd, input logic wr, input logic [25:0] addr, input logic [31:0] wd,
                     input int ack, input logic [31:0] xr, input logic hold);
    logic [31:0] cyc;
    logic [1:0]  rg;
    logic [3:0]  idx;
    logic        ev, acked;
    int          n;
    rg = addr[25:24];
    idx = addr[3:0];
    acked = 1'b0;
    bus.memory_read_req = rd;
    bus.memory_write_req = wr;
    bus.memory_addr = addr;
    bus.memory_data_write = wd;
    @(posedge clk);
    #1;
    if (!hold || rg == 2'b01) drop_reqs();
    cyc = tb_cyc;
    chk("busy_rise", 32'(bus.memory_busy), 32'd1);
    if (rg == 2'b01) begin
      chk("ext_req", 32'(ext_req), 32'd1);
      chk("ext_addr", 32'(ext_addr), 32'(addr[23:0]));
      chk("ext_we", 32'(ext_we), 32'(wr));
      if (wr) chk("ext_wdata", ext_wdata, wd);
      n = 0;
      while (ext_req && n < TO + 10) begin
        n++;
        ext_ack = n == ack;
        ext_rdata = xr;
        @(posedge clk);
        #1 ext_ack = 1'b0;
      end
      acked = ack >= 1 && ack <= TO;
      chk("ext_len", 32'(n), acked ? 32'(ack) : 32'(TO));
    end else begin
      @(posedge clk);
      #1 drop_reqs();
    end
    chk("busy_fall", 32'(bus.memory_busy), 32'd0);
    ev = (rd && wr) || rg[1] || (rg == 2'b01 && !acked);
    if (rd && !wr) begin
      if (rg == 2'b00) begin
        case (idx)
          4'd0: m_data = ID;
          4'd1: m_data = m_reg1;
          4'd2: m_data = m_reg2;
          4'd3: m_data = cyc;
          4'd4: m_data = 32'(m_err);
          default: m_data = 0;
        endcase
      end else m_data = (rg == 2'b01 && acked) ? xr : UW;
    end
    if (rg == 2'b00 && wr && idx == 4'd4) m_err = 0;
    else if (ev && m_err < 65535) m_err++;
    if (rg == 2'b00 && wr && idx == 4'd1) m_reg1 = wd;
    if (rg == 2'b00 && wr && idx == 4'd2) m_reg2 = wd;
    chk("rdata", bus.memory_data_read, m_data);
    chk("led", 32'(led_ctrl), 32'(m_reg2[3:0]));
  endtask
  initial begin
    logic [1:0]  rg;
    logic [25:0] a;
    logic        rd, wr;
    int          op, ack;
    bus.memory_addr = 0;
    bus.memory_data_write = 0;
    ext_rdata = 0;
    do_reset();
    chk("rst_busy", 32'(bus.memory_busy), 32'd0);
    chk("rst_rdata", bus.memory_data_read, 32'd0);
    chk("rst_ext_req", 32'(ext_req), 32'd0);
    chk("rst_ext_we", 32'(ext_we), 32'd0);
    chk("rst_ext_addr", 32'(ext_addr), 32'd0);
    chk("rst_ext_wdata", ext_wdata, 32'd0);
    chk("rst_led", 32'(led_ctrl), 32'd0);
    txn(1, 0, 26'h000_0000, 0, 0, 0, 0);
    txn(0, 1, 26'h000_0002, 32'h0000_000A, 0, 0, 0);
    chk("led_a", 32'(led_ctrl), 32'hA);
    txn(1, 0, 26'h000_0002, 0, 0, 0, 1);
    txn(1, 0, 26'h100_0123, 0, 6, 32'h1234_5678, 0);
    txn(0, 1, 26'h1AB_CDEF, 32'hCAFE_F00D, 0, 0, 0);
    txn(1, 0, 26'h000_0004, 0, 0, 0, 0);
    txn(0, 1, 26'h000_0004, 0, 0, 0, 0);
    txn(1, 0, 26'h200_0000, 0, 0, 0, 0);
    txn(1, 1, 26'h000_0001, 32'h55, 0, 0, 0);
    txn(1, 0, 26'h000_0004, 0, 0, 0, 0);
    txn(0, 1, 26'h000_0004, 0, 0, 0, 0);
    txn(1, 0, 26'h000_0001, 0, 0, 0, 0);
    txn(1, 0, 26'h000_0003, 0, 0, 0, 0);
    bus.memory_read_req = 1'b1;
    bus.memory_addr = 26'h100_0000;
    @(posedge clk);
    #1 drop_reqs();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    chk("rst_mid_busy", 32'(bus.memory_busy), 32'd0);
    chk("rst_mid_ext_req", 32'(ext_req), 32'd0);
    ext_ack = 1'b1;
    ext_rdata = 32'hBAD0_BAD0;
    @(posedge clk);
    #1 ext_ack = 1'b0;
    chk("late_ack_busy", 32'(bus.memory_busy), 32'd0);
    chk("late_ack_ext_req", 32'(ext_req), 32'd0);
    chk("late_ack_rdata", bus.memory_data_read, 32'd0);
    txn(1, 0, 26'h000_0004, 0, 0, 0, 0);
    for (int i = 0; i < 150; i++) begin
      rg = 2'($urandom_range(0, 3));
      a = {rg, 24'($urandom)};
      if (rg == 2'b00) a[3:0] = 4'($urandom_range(0, 7));
      op = $urandom_range(0, 9);
      rd = op <= 4 || (op == 9);
      wr = op >= 5 && !(op == 9 && rg != 2'b00);
      ack = $urandom_range(0, 19) == 0 ? 0 : $urandom_range(1, 12);
      txn(rd, wr, a, $urandom, ack, $urandom, 1'($urandom_range(0, 1)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
